// File: rtl/idex_stage.sv
// ============================================================================
// Module   : idex_stage
// Brief    : ID/EX pipeline register with load-use hazard detection.
//            Detection and bubble-on-stall are built only when
//            LOAD_USE_DETECT_EN is defined; otherwise stall is tied low.
// Revision : 1.0
// ============================================================================
`default_nettype none

module idex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,

    input  logic [REG_W-1:0]  ID_regRs,
    input  logic [REG_W-1:0]  ID_regRt,
    input  logic [REG_W-1:0]  ID_regRd,
    input  logic [DATA_W-1:0] ID_readData1,
    input  logic [DATA_W-1:0] ID_readData2,
    input  logic [DATA_W-1:0] ID_signExt,
    input  logic              ID_regWrite,
    input  logic              ID_memRead,
    input  logic              ID_memWrite,
    input  logic              ID_memToReg,
    input  logic              ID_aluSrc,
    input  logic              ID_regDst,
    input  logic [3:0]        ID_aluCtrl,

    output logic [REG_W-1:0]  IDEX_regRs,
    output logic [REG_W-1:0]  IDEX_regRt,
    output logic [REG_W-1:0]  IDEX_regRd,
    output logic [DATA_W-1:0] IDEX_readData1,
    output logic [DATA_W-1:0] IDEX_readData2,
    output logic [DATA_W-1:0] IDEX_signExt,
    output logic              IDEX_regWrite,
    output logic              IDEX_memRead,
    output logic              IDEX_memWrite,
    output logic              IDEX_memToReg,
    output logic              IDEX_aluSrc,
    output logic              IDEX_regDst,
    output logic [3:0]        IDEX_aluCtrl,
    output logic              IDEX_valid,
    output logic              stall
);

    localparam logic [REG_W-1:0] c_REG_ZERO = '0;

    logic [REG_W-1:0]  r_regRs;
    logic [REG_W-1:0]  r_regRt;
    logic [REG_W-1:0]  r_regRd;
    logic [DATA_W-1:0] r_readData1;
    logic [DATA_W-1:0] r_readData2;
    logic [DATA_W-1:0] r_signExt;
    logic              r_regWrite;
    logic              r_memRead;
    logic              r_memWrite;
    logic              r_memToReg;
    logic              r_aluSrc;
    logic              r_regDst;
    logic [3:0]        r_aluCtrl;
    logic              r_valid;

    logic              w_stall;
    logic              w_bubble;

`ifdef LOAD_USE_DETECT_EN
    logic              w_hazard;

    // A load into $0 produces nothing worth waiting for, so it never stalls.
    assign w_hazard = r_memRead
                    & (r_regRt != c_REG_ZERO)
                    & ((r_regRt == ID_regRs) | (r_regRt == ID_regRt));
    assign w_stall  = w_hazard & ~flush;
`else
    assign w_stall  = 1'b0;
`endif

    assign w_bubble = flush | w_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_regRs     <= c_REG_ZERO;
            r_regRt     <= c_REG_ZERO;
            r_regRd     <= c_REG_ZERO;
            r_readData1 <= '0;
            r_readData2 <= '0;
            r_signExt   <= '0;
            r_regWrite  <= 1'b0;
            r_memRead   <= 1'b0;
            r_memWrite  <= 1'b0;
            r_memToReg  <= 1'b0;
            r_aluSrc    <= 1'b0;
            r_regDst    <= 1'b0;
            r_aluCtrl   <= 4'd0;
            r_valid     <= 1'b0;
        end else if (w_bubble) begin
            // Zeroed specifiers keep the forwarding unit from matching a bubble.
            r_regRs     <= c_REG_ZERO;
            r_regRt     <= c_REG_ZERO;
            r_regRd     <= c_REG_ZERO;
            r_readData1 <= '0;
            r_readData2 <= '0;
            r_signExt   <= '0;
            r_regWrite  <= 1'b0;
            r_memRead   <= 1'b0;
            r_memWrite  <= 1'b0;
            r_memToReg  <= 1'b0;
            r_aluSrc    <= 1'b0;
            r_regDst    <= 1'b0;
            r_aluCtrl   <= 4'd0;
            r_valid     <= 1'b0;
        end else begin
            r_regRs     <= ID_regRs;
            r_regRt     <= ID_regRt;
            r_regRd     <= ID_regRd;
            r_readData1 <= ID_readData1;
            r_readData2 <= ID_readData2;
            r_signExt   <= ID_signExt;
            r_regWrite  <= ID_regWrite;
            r_memRead   <= ID_memRead;
            r_memWrite  <= ID_memWrite;
            r_memToReg  <= ID_memToReg;
            r_aluSrc    <= ID_aluSrc;
            r_regDst    <= ID_regDst;
            r_aluCtrl   <= ID_aluCtrl;
            r_valid     <= 1'b1;
        end
    end

    assign IDEX_regRs     = r_regRs;
    assign IDEX_regRt     = r_regRt;
    assign IDEX_regRd     = r_regRd;
    assign IDEX_readData1 = r_readData1;
    assign IDEX_readData2 = r_readData2;
    assign IDEX_signExt   = r_signExt;
    assign IDEX_regWrite  = r_regWrite;
    assign IDEX_memRead   = r_memRead;
    assign IDEX_memWrite  = r_memWrite;
    assign IDEX_memToReg  = r_memToReg;
    assign IDEX_aluSrc    = r_aluSrc;
    assign IDEX_regDst    = r_regDst;
    assign IDEX_aluCtrl   = r_aluCtrl;
    assign IDEX_valid     = r_valid;
    assign stall          = w_stall;

endmodule

`default_nettype wire

// File: tb/tb_idex_stage.sv
// ============================================================================
// Module   : tb_idex_stage
// Brief    : Self-checking bench for idex_stage (honours LOAD_USE_DETECT_EN).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_idex_stage;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

`ifdef LOAD_USE_DETECT_EN
    localparam bit c_DETECT = 1'b1;
`else
    localparam bit c_DETECT = 1'b0;
`endif

    typedef struct packed {
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [DATA_W-1:0] se;
        logic              regWrite;
        logic              memRead;
        logic              memWrite;
        logic              memToReg;
        logic              aluSrc;
        logic              regDst;
        logic [3:0]        aluCtrl;
    } instr_t;

    typedef struct {
        instr_t in;
        logic   fl;
        logic   exp_stall;
        instr_t exp_out;
        logic   exp_valid;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    instr_t drv;

    logic [REG_W-1:0]  IDEX_regRs, IDEX_regRt, IDEX_regRd;
    logic [DATA_W-1:0] IDEX_readData1, IDEX_readData2, IDEX_signExt;
    logic IDEX_regWrite, IDEX_memRead, IDEX_memWrite, IDEX_memToReg;
    logic IDEX_aluSrc, IDEX_regDst, IDEX_valid, stall;
    logic [3:0] IDEX_aluCtrl;

    int checks = 0;
    int errors = 0;

    // Reference model: contents of the EX slot
    instr_t m_slot;
    logic   m_valid;
    logic   last_stall;

    always #5 clk = ~clk;

    idex_stage #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .ID_regRs(drv.rs), .ID_regRt(drv.rt), .ID_regRd(drv.rd),
        .ID_readData1(drv.rd1), .ID_readData2(drv.rd2), .ID_signExt(drv.se),
        .ID_regWrite(drv.regWrite), .ID_memRead(drv.memRead),
        .ID_memWrite(drv.memWrite), .ID_memToReg(drv.memToReg),
        .ID_aluSrc(drv.aluSrc), .ID_regDst(drv.regDst), .ID_aluCtrl(drv.aluCtrl),
        .IDEX_regRs(IDEX_regRs), .IDEX_regRt(IDEX_regRt), .IDEX_regRd(IDEX_regRd),
        .IDEX_readData1(IDEX_readData1), .IDEX_readData2(IDEX_readData2),
        .IDEX_signExt(IDEX_signExt), .IDEX_regWrite(IDEX_regWrite),
        .IDEX_memRead(IDEX_memRead), .IDEX_memWrite(IDEX_memWrite),
        .IDEX_memToReg(IDEX_memToReg), .IDEX_aluSrc(IDEX_aluSrc),
        .IDEX_regDst(IDEX_regDst), .IDEX_aluCtrl(IDEX_aluCtrl),
        .IDEX_valid(IDEX_valid), .stall(stall)
    );

    function automatic instr_t act();
        instr_t a;
        a.rs = IDEX_regRs;          a.rt = IDEX_regRt;       a.rd = IDEX_regRd;
        a.rd1 = IDEX_readData1;     a.rd2 = IDEX_readData2;  a.se = IDEX_signExt;
        a.regWrite = IDEX_regWrite; a.memRead = IDEX_memRead;
        a.memWrite = IDEX_memWrite; a.memToReg = IDEX_memToReg;
        a.aluSrc = IDEX_aluSrc;     a.regDst = IDEX_regDst;  a.aluCtrl = IDEX_aluCtrl;
        return a;
    endfunction

    task automatic check(input string name, input logic [127:0] a, input logic [127:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, a, e);
        end
    endtask

    // Load-use rule evaluated against the instruction sitting in EX.
    function automatic logic model_stall(input instr_t in, input logic fl);
        logic uses;
        uses = (m_slot.rt == in.rs) || (m_slot.rt == in.rt);
        return c_DETECT && m_slot.memRead && (m_slot.rt != 0) && uses && !fl;
    endfunction

    // Starts just after a rising edge; ends 1 time unit after the next one.
    task automatic step(input instr_t in, input logic fl);
        logic es;
        drv = in;
        flush = fl;
        #2;
        es = model_stall(in, fl);
        last_stall = stall;
        check("stall", {127'd0, stall}, {127'd0, es});
        if (fl || es) begin
            m_slot = '0;
            m_valid = 1'b0;
        end else begin
            m_slot = in;
            m_valid = 1'b1;
        end
        @(posedge clk);
        #1;
        check("idex_bus", {7'd0, act()}, {7'd0, m_slot});
        check("idex_valid", {127'd0, IDEX_valid}, {127'd0, m_valid});
    endtask

    function automatic instr_t mk_lw(input int rs, input int rt);
        instr_t i = '0;
        i.rs = REG_W'(rs); i.rt = REG_W'(rt); i.se = 32'h0000_0010;
        i.rd1 = 32'h1000_0000;
        i.regWrite = 1'b1; i.memRead = 1'b1; i.memToReg = 1'b1; i.aluSrc = 1'b1;
        i.aluCtrl = 4'd2;
        return i;
    endfunction

    function automatic instr_t mk_add(input int rs, input int rt, input int rd);
        instr_t i = '0;
        i.rs = REG_W'(rs); i.rt = REG_W'(rt); i.rd = REG_W'(rd);
        i.rd1 = 32'h0000_00AA; i.rd2 = 32'h0000_0055;
        i.regWrite = 1'b1; i.regDst = 1'b1; i.aluCtrl = 4'd2;
        return i;
    endfunction

    function automatic instr_t rnd_instr();
        instr_t i;
        i.rs = REG_W'($urandom_range(0, 3));
        i.rt = REG_W'($urandom_range(0, 3));
        i.rd = REG_W'($urandom);
        i.rd1 = $urandom; i.rd2 = $urandom; i.se = $urandom;
        i.regWrite = 1'($urandom); i.memRead = 1'($urandom);
        i.memWrite = 1'($urandom); i.memToReg = 1'($urandom);
        i.aluSrc = 1'($urandom);   i.regDst = 1'($urandom);
        i.aluCtrl = 4'($urandom);
        return i;
    endfunction

    vec_t vecs[7];
    instr_t add8;

    initial begin
        drv = '1;
        m_slot = '0;
        m_valid = 1'b0;
        last_stall = 1'b0;

        // Reset with non-zero inputs
        @(posedge clk);
        #1;
        check("rst_bus", {7'd0, act()}, 128'd0);
        check("rst_valid", {127'd0, IDEX_valid}, 128'd0);
        check("rst_stall", {127'd0, stall}, 128'd0);

        // Release: first edge captures normally
        rst = 1'b0;
        drv = '0;
        drv.rs = 5'd3;
        drv.rd1 = 32'h1234;
        step(drv, 1'b0);
        check("rel_rs", {123'd0, IDEX_regRs}, 128'd3);
        check("rel_rd1", {96'd0, IDEX_readData1}, 128'h1234);

        // Directed table: load-use, load to $0, flush priority
        add8 = mk_add(8, 9, 10);
        vecs[0] = '{mk_lw(2, 8),   1'b0, 1'b0,     mk_lw(2, 8), 1'b1};
        vecs[1] = '{add8,          1'b0, c_DETECT, c_DETECT ? instr_t'('0) : add8, !c_DETECT};
        vecs[2] = '{add8,          1'b0, 1'b0,     add8, 1'b1};
        vecs[3] = '{mk_lw(4, 0),   1'b0, 1'b0,     mk_lw(4, 0), 1'b1};
        vecs[4] = '{mk_add(0, 0, 7), 1'b0, 1'b0,   mk_add(0, 0, 7), 1'b1};
        vecs[5] = '{mk_lw(2, 8),   1'b0, 1'b0,     mk_lw(2, 8), 1'b1};
        vecs[6] = '{add8,          1'b1, 1'b0,     instr_t'('0), 1'b0};
        for (int k = 0; k < 7; k++) begin
            step(vecs[k].in, vecs[k].fl);
            check($sformatf("tbl%0d_stall", k), {127'd0, last_stall}, {127'd0, vecs[k].exp_stall});
            check($sformatf("tbl%0d_bus", k), {7'd0, act()}, {7'd0, vecs[k].exp_out});
            check($sformatf("tbl%0d_valid", k), {127'd0, IDEX_valid}, {127'd0, vecs[k].exp_valid});
        end

        // Reset asserted in the middle of a stall cycle
        step(mk_lw(1, 8), 1'b0);
        drv = add8;
        flush = 1'b0;
        #2;
        check("mid_stall_pre", {127'd0, stall}, {127'd0, c_DETECT});
        rst = 1'b1;
        #1;
        check("mid_stall_drop", {127'd0, stall}, 128'd0);
        check("mid_rst_bus", {7'd0, act()}, 128'd0);
        check("mid_rst_valid", {127'd0, IDEX_valid}, 128'd0);
        #1;
        rst = 1'b0;
        m_slot = add8;
        m_valid = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_bus", {7'd0, act()}, {7'd0, add8});
        check("post_rst_valid", {127'd0, IDEX_valid}, 128'd1);

        // Randomised traffic against the model
        for (int n = 0; n < 400; n++) begin
            step(rnd_instr(), ($urandom_range(0, 7) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
